mul8_dot_acc: RTL

Streaming dot-product accumulator that sits directly downstream of the 8-bit approximate multipliers. It consumes one 16-bit product per beat over a valid/ready handshake and sums the products of a vector (terminated by `P_LAST`) into a saturating accumulator. It presents each finished sum in a one-entry output register with its own valid/ready handshake. This is the first clocked stage after the combinational multiplier array and feeds the error-statistics/readout logic.

---
 rtl/mul8_pkg.sv | 33 +++
 rtl/mul8_acc_outreg.sv | 47 ++++
 rtl/mul8_dot_acc.sv | 111 +++++++++++
 3 files changed

// File: rtl/mul8_pkg.sv
// Shared definitions for the mul8 multiplier datapath: product width, accumulator
// state encoding and the saturating adder used by the accumulator stages.
package mul8_pkg;

  localparam int MUL8_PW   = 16;
  // Widest accumulator sat_add supports; callers slice the low `width` bits.
  localparam int SAT_MAX_W = 48;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

  typedef struct packed {
    logic                 ovf;
    logic [SAT_MAX_W-1:0] sum;
  } sat_add_t;

  // base must already fit in `width` bits, so any carry past the limit means overflow.
  function automatic sat_add_t sat_add(input logic [SAT_MAX_W-1:0] base,
                                       input logic [MUL8_PW-1:0]   p,
                                       input int unsigned          width);
    sat_add_t           r;
    logic [SAT_MAX_W:0] full;
    logic [SAT_MAX_W:0] lim;
    full  = {1'b0, base} + {{(SAT_MAX_W + 1 - MUL8_PW){1'b0}}, p};
    lim   = ((SAT_MAX_W + 1)'(1) << width) - (SAT_MAX_W + 1)'(1);
    r.ovf = (full > lim);
    r.sum = r.ovf ? lim[SAT_MAX_W-1:0] : full[SAT_MAX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/mul8_acc_outreg.sv
// One-entry result register with valid/ready; a load may coincide with the
// consumer taking the current entry, giving back-to-back results with no bubble.
module mul8_acc_outreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Valid/ready: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never depends on ready, and the producer holds its data until it transfers.
  // load must only be asserted while in_ready is 1.
  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    in_ready = ~valid_q | out_ready;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/mul8_dot_acc.sv
// Streaming saturating dot-product accumulator: sums 16-bit products per vector
// (closed by P_LAST or the term limit) and presents each sum in a result register.
module mul8_dot_acc
  import mul8_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [MUL8_PW-1:0] P,
  input  logic               P_VALID,
  input  logic               P_LAST,
  output logic               P_READY,
  output logic [ACC_W-1:0]   S,
  output logic [CNT_W:0]     S_CNT,
  output logic               S_SAT,
  output logic               S_FORCED,
  output logic               S_VALID,
  input  logic               S_READY,
  output logic               dbg_state
);

  localparam int             RES_W     = ACC_W + CNT_W + 3;
  localparam logic [CNT_W:0] CNT_LIMIT = {1'b1, {CNT_W{1'b0}}};

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W:0]   cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic [ACC_W-1:0] acc_base, acc_sum;
  logic [CNT_W:0]   cnt_base, cnt_inc;
  logic             sat_base, sat_now;
  sat_add_t         sum_r;
  logic             beat_accept, beat_final, res_load, res_in_ready;
  logic [RES_W-1:0] res_in, res_out;

  always_comb begin
    acc_base    = (state_q == ACCUM) ? acc_q : '0;
    cnt_base    = (state_q == ACCUM) ? cnt_q : '0;
    sat_base    = (state_q == ACCUM) ? sat_q : 1'b0;
    sum_r       = sat_add(SAT_MAX_W'(acc_base), P, ACC_W);
    acc_sum     = sum_r.sum[ACC_W-1:0];
    sat_now     = sat_base | sum_r.ovf;
    cnt_inc     = cnt_base + (CNT_W + 1)'(1);
    P_READY     = ~RST & res_in_ready;
    beat_accept = P_VALID & P_READY;
    // The term limit closes a vector even without P_LAST, so cnt never wraps.
    beat_final  = P_LAST | (cnt_inc == CNT_LIMIT);
    res_load    = beat_accept & beat_final;
    res_in      = {acc_sum, cnt_inc, sat_now, ~P_LAST};

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (beat_accept) begin
      if (beat_final) begin
        state_d = EMPTY;
        acc_d   = '0;
        cnt_d   = '0;
        sat_d   = 1'b0;
      end else begin
        state_d = ACCUM;
        acc_d   = acc_sum;
        cnt_d   = cnt_inc;
        sat_d   = sat_now;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= EMPTY;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  if (ACC_W < SAT_MAX_W) begin : g_sum_hi
    logic sum_hi_unused;
    assign sum_hi_unused = ^sum_r.sum[SAT_MAX_W-1:ACC_W];
  end

  mul8_acc_outreg #(
    .W(RES_W)
  ) u_outreg (
    .clk      (CLK),
    .rst      (RST),
    .load     (res_load),
    .in_data  (res_in),
    .in_ready (res_in_ready),
    .out_ready(S_READY),
    .out_valid(S_VALID),
    .out_data (res_out)
  );

  assign S         = res_out[RES_W-1 -: ACC_W];
  assign S_CNT     = res_out[CNT_W+2 -: CNT_W+1];
  assign S_SAT     = res_out[1];
  assign S_FORCED  = res_out[0];
  assign dbg_state = state_q;

endmodule
